// File: rtl/sequential_magnitude_comparator_pkg.sv
// Shared defaults, state and result encodings for the sequential magnitude comparator.
package sequential_magnitude_comparator_pkg;

  localparam int WIDTH_DEF   = 24;
  localparam int SLICE_DEF   = 6;
  localparam int NSLICES_DEF = WIDTH_DEF / SLICE_DEF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } res_e;

  // Cascade bits are {gt, lt, eq}; gt wins over lt, and anything else
  // (including all-zero) reads as equal.
  function automatic res_e norm_cascade(input logic [2:0] casc);
    res_e r;
    casez (casc)
      3'b1??:  r = RES_GT;
      3'b01?:  r = RES_LT;
      default: r = RES_EQ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sequential_magnitude_comparator_slice_compare_cascade.sv
// One unsigned slice compare; an equal slice passes the incoming running result through.
module slice_compare_cascade
  import sequential_magnitude_comparator_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  res_e             res_i,
  output res_e             res_o
);

  always_comb begin
    res_o = res_i;
    if (a_i > b_i) begin
      res_o = RES_GT;
    end else if (a_i < b_i) begin
      res_o = RES_LT;
    end
  end

endmodule

// File: rtl/sequential_magnitude_comparator.sv
// Multi-cycle magnitude comparator: one SLICE-bit slice per clock, least-significant first.
// state  | meaning
// S_IDLE | waiting for start; result outputs hold the last completed compare
// S_RUN  | walking slices, running result kept in run_q
module sequential_magnitude_comparator
  import sequential_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gti,
  input  logic             lti,
  input  logic             eqi,
  output logic             busy,
  output logic             done,
  output logic             gto,
  output logic             lto,
  output logic             eqo
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  res_e              run_q;
  res_e              run_d;
  logic              busy_q;
  logic              done_q;
  logic              gto_q;
  logic              lto_q;
  logic              eqo_q;
  logic [SLICE-1:0]  a_slice;
  logic [SLICE-1:0]  b_slice;

  always_comb begin
    a_slice = a_q[idx_q*SLICE +: SLICE];
    b_slice = b_q[idx_q*SLICE +: SLICE];
  end

  slice_compare_cascade #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i   (a_slice),
    .b_i   (b_slice),
    .res_i (run_q),
    .res_o (run_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gto_q   <= 1'b0;
      lto_q   <= 1'b0;
      eqo_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            run_q   <= norm_cascade({gti, lti, eqi});
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          run_q <= run_d;
          idx_q <= idx_q + IDXW'(1);
          // Last slice: publish the result on the same edge it is computed.
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gto_q   <= (run_d == RES_GT);
            lto_q   <= (run_d == RES_LT);
            eqo_q   <= (run_d == RES_EQ);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gto  = gto_q;
  assign lto  = lto_q;
  assign eqo  = eqo_q;

endmodule
